alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked execution unit for the datapath. It supersedes the purely combinational ALU. It adds unsigned, signed-compare and shift operations and an iterative unsigned multiply/divide path. Results are registered, and operand acceptance uses a valid/ready handshake so the core controller can stall on long operations.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; power of two, ≥ 8.
- `OPCODE_LENGTH`, default 4: operation code width; fixed at 4 for the current encoding.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands and operation are presented.
- `in_ready`, output, 1: unit can accept (high only in IDLE, low while `reset` high).
- `SrcA`, input, DATA_WIDTH: operand A.
- `SrcB`, input, DATA_WIDTH: operand B.
- `Operation`, input, OPCODE_LENGTH: operation code.
- `out_valid`, output, 1: `ALUResult`/`Zero` valid.
- `out_ready`, input, 1: consumer takes the result.
- `ALUResult`, output, DATA_WIDTH: registered result.
- `Zero`, output, 1: registered `ALUResult == 0`.

## Operation
- Encoding: 0000 AND, 0001 OR (bitwise), 0010 ADD, 0011 SUB, 0100 SLL, 0101 SRL, 0110 XOR, 0111 SRA, 1000 EQ, 1001 NE, 1010 SLT (signed), 1011 SLTU, 1100 MUL (low half), 1101 MULHU (high half, unsigned), 1110 DIVU, 1111 REMU.
- ADD/SUB wrap modulo 2^DATA_WIDTH. No overflow flag.
- Compares return 1 or 0, zero-extended.
- Shift amount is `SrcB[$clog2(DATA_WIDTH)-1:0]`; upper bits are ignored. SRA replicates `SrcA` MSB.
- Operands and opcode are captured on acceptance (`in_valid && in_ready`). Inputs are don't-care afterwards.
- States:
  - IDLE: `in_ready`=1. On acceptance, codes 0000–1011 compute, register the result and go to DONE. Codes 11xx go to BUSY.
  - BUSY: one iteration per cycle, DATA_WIDTH cycles, counted by a `$clog2(DATA_WIDTH)+1`-bit counter. After the last iteration, register the result and go to DONE.
  - DONE: `out_valid`=1. `ALUResult` and `Zero` are held stable. On `out_ready`, go to IDLE.
- MUL/MULHU use a shift-add over a 2·DATA_WIDTH product register. MUL returns bits [W-1:0]; MULHU returns bits [2W-1:W].
- DIVU/REMU use a restoring divider. For divisor 0: DIVU returns all ones and REMU returns `SrcA`, both with normal latency (no early exit).
- Reset values: state IDLE, `out_valid`=0, `ALUResult`=0, `Zero`=0, counter 0.
- Reset in BUSY or DONE aborts the operation and discards the result. `in_ready` is high the cycle after reset deasserts.

## Timing
- Acceptance at edge N. For a single-cycle op, `out_valid` is high in cycle N+1. For MUL/MULHU/DIVU/REMU, `out_valid` is high in cycle N+1+DATA_WIDTH (N+33 at default).
- No overlap: `in_ready`=0 in BUSY and DONE, so there is no accept on the same edge as the result handshake. The earliest next accept is the edge after `out_valid && out_ready`.
- `out_valid` stays high with an unchanged result until `out_ready`, including indefinite backpressure.
- `in_ready` is combinational from state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `alu_pkg`: `alu_op_e` enum (the 16 codes above) and `alu_state_e` (IDLE, BUSY, DONE).
- Sub-module `mdu_iter`: iterative multiplier/divider holding the product/remainder registers, the iteration counter and a `done` pulse. It is started by `alu_seq` with operands and `is_div`/`want_hi`/`want_rem` selects.
- `alu_seq` holds the FSM, the combinational single-cycle datapath and the output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 → 0x80000000, `Zero`=0, `out_valid` one cycle after accept. SUB 5−5 → 0, `Zero`=1.
- SLT 0xFFFFFFFF,1 → 1; SLTU same operands → 0; SRA 0x80000000 by 0x24 (amount 4) → 0xF8000000; OR 0x0F0,0x00F → 0x0FF.
- MUL 0xFFFFFFFF·2 → 0xFFFFFFFE; MULHU same operands → 0x00000001. `out_valid` exactly 33 cycles after accept; `in_ready`=0 throughout.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 123/0 → 0xFFFFFFFF; REMU 123/0 → 123. All at 33-cycle latency.
- Backpressure: hold `out_ready`=0 for 10 cycles after an XOR result, with new `in_valid` and changing inputs. The result is stable, no accept occurs, and the next op is accepted only after the handshake.
- Assert `reset` in BUSY cycle 10 of a DIVU. `out_valid` never rises, all outputs are 0, and the unit accepts a new op on the first cycle after reset deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_EQ    = 4'b1000,
    OP_NE    = 4'b1001,
    OP_SLT   = 4'b1010,
    OP_SLTU  = 4'b1011,
    OP_MUL   = 4'b1100,
    OP_MULHU = 4'b1101,
    OP_DIVU  = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Codes 11xx go through the iterative multiply/divide unit.
  function automatic logic is_iterative(input alu_op_e op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one step per
// cycle for DATA_WIDTH cycles. The upper half of acc_reg holds the partial
// product high word or the running remainder; the lower half holds the
// multiplier being shifted out or the dividend/quotient being shifted through.
// done and result are combinational on the final step so the caller can
// register the answer on the same edge as the last iteration.
module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_div,
  input  logic                  want_hi,
  input  logic                  want_rem,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  logic [2*W-1:0] acc_reg;
  logic [W-1:0]   opb_reg;
  logic           is_div_reg;
  logic           sel_hi_reg;
  logic           busy_reg;
  logic [CW-1:0]  cnt_reg;

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift;
  logic [W-1:0]   div_trial;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] acc_next;

  // One multiply or divide step from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
    mul_next  = {mul_sum, acc_reg[W-1:1]};
    div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
    div_ge    = (div_shift >= {1'b0, opb_reg});
    // The true difference is below the divisor, so W bits hold it exactly.
    div_trial = div_shift[W-1:0] - opb_reg;
    div_next  = div_ge ? {div_trial, acc_reg[W-2:0], 1'b1}
                       : {div_shift[W-1:0], acc_reg[W-2:0], 1'b0};
    acc_next  = is_div_reg ? div_next : mul_next;
    done      = busy_reg && (cnt_reg == LAST_CNT);
    result    = sel_hi_reg ? acc_next[2*W-1:W] : acc_next[W-1:0];
  end

  // Load operands on start, then iterate until the counter hits the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      opb_reg    <= '0;
      is_div_reg <= 1'b0;
      sel_hi_reg <= 1'b0;
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else if (start) begin
      acc_reg    <= {{W{1'b0}}, a};
      opb_reg    <= b;
      is_div_reg <= is_div;
      // MULHU and REMU both live in the upper half of the accumulator.
      sel_hi_reg <= is_div ? want_rem : want_hi;
      busy_reg   <= 1'b1;
      cnt_reg    <= '0;
    end else if (busy_reg) begin
      acc_reg <= acc_next;
      if (done) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execution unit: single-cycle ALU ops plus iterative MUL/DIV,
// with a registered result held until the consumer takes it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam int SHW = $clog2(DATA_WIDTH);

  alu_state_e            state_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  zero_reg;
  logic                  out_valid_reg;

  alu_op_e               op;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  accept;
  logic                  mdu_start;
  logic                  mdu_done;
  logic [DATA_WIDTH-1:0] mdu_result;

  assign op        = alu_op_e'(Operation);
  assign shamt     = SrcB[SHW-1:0];
  assign in_ready  = (state_reg == ST_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign mdu_start = accept && is_iterative(op);

  assign out_valid = out_valid_reg;
  assign ALUResult = result_reg;
  assign Zero      = zero_reg;

  // Single-cycle datapath evaluated on the presented operands.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_AND:  alu_result = SrcA & SrcB;
      OP_OR:   alu_result = SrcA | SrcB;
      OP_ADD:  alu_result = SrcA + SrcB;
      OP_SUB:  alu_result = SrcA - SrcB;
      OP_SLL:  alu_result = SrcA << shamt;
      OP_SRL:  alu_result = SrcA >> shamt;
      OP_XOR:  alu_result = SrcA ^ SrcB;
      OP_SRA:  alu_result = $signed(SrcA) >>> shamt;
      OP_EQ:   alu_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_NE:   alu_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
      OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
      default: alu_result = '0;
    endcase
  end

  mdu_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .start    (mdu_start),
    .is_div   (op[1]),
    .want_hi  (op[0]),
    .want_rem (op[0]),
    .a        (SrcA),
    .b        (SrcB),
    .done     (mdu_done),
    .result   (mdu_result)
  );

  // Controller: accept in IDLE, wait on the iterative unit in BUSY, hold in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (is_iterative(op)) begin
              state_reg <= ST_BUSY;
            end else begin
              result_reg    <= alu_result;
              zero_reg      <= (alu_result == '0);
              out_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (mdu_done) begin
            result_reg    <= mdu_result;
            zero_reg      <= (mdu_result == '0);
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic reference.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [3:0]   Operation;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         Zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .DATA_WIDTH(W),
    .OPCODE_LENGTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  // Reference: plain arithmetic on wide integers.
  function automatic logic [31:0] ref_model(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] prod;
    int unsigned sh;
    sh   = b % 32;
    prod = 64'(a) * 64'(b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return a << sh;
      4'd5:  return a >> sh;
      4'd6:  return a ^ b;
      4'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return (a != b) ? 32'd1 : 32'd0;
      4'd10: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd11: return (a < b) ? 32'd1 : 32'd0;
      4'd12: return prod[31:0];
      4'd13: return prod[63:32];
      4'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op from IDLE (caller is #1 after a rising edge), check result,
  // latency, in_ready behaviour, and complete the output handshake.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int exp_lat;
    int lat;
    int ready_leak;
    exp        = ref_model(op, a, b);
    exp_lat    = (op >= 4'd12) ? W + 1 : 1;
    ready_leak = 0;

    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before got=%b want=1", tag, in_ready);
    end

    in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    in_valid = 1'b0; Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;

    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) ready_leak++;
      @(posedge clk); #1;
      lat++;
    end

    $display("op=%0d a=%h b=%h res=%h zero=%b lat=%0d (%s)",
             op, a, b, ALUResult, Zero, lat, tag);

    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", tag, lat, exp_lat);
    end
    total++;
    if (ALUResult !== exp) begin
      bad++;
      $display("FAIL %s result got=%h want=%h", tag, ALUResult, exp);
    end
    total++;
    if (Zero !== (exp == 32'd0)) begin
      bad++;
      $display("FAIL %s zero got=%b want=%b", tag, Zero, (exp == 32'd0));
    end
    total++;
    if (ready_leak != 0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_while_busy got=%0d cycles high, now=%b want=0",
               tag, ready_leak, in_ready);
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s after_handshake got valid=%b ready=%b want valid=0 ready=1",
               tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 4'd0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || ALUResult !== 32'd0 || Zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got ready=%b valid=%b res=%h zero=%b want 0 0 0 0",
               in_ready, out_valid, ALUResult, Zero);
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    $display("reset sequence done");
  endtask

  task automatic test_directed();
    run_op(4'd2,  32'h7FFF_FFFF, 32'h1,         "add_wrap");
    run_op(4'd3,  32'd5,         32'd5,         "sub_zero");
    run_op(4'd10, 32'hFFFF_FFFF, 32'd1,         "slt");
    run_op(4'd11, 32'hFFFF_FFFF, 32'd1,         "sltu");
    run_op(4'd7,  32'h8000_0000, 32'h24,        "sra");
    run_op(4'd1,  32'h0F0,       32'h00F,       "or");
    run_op(4'd12, 32'hFFFF_FFFF, 32'd2,         "mul");
    run_op(4'd13, 32'hFFFF_FFFF, 32'd2,         "mulhu");
    run_op(4'd14, 32'd100,       32'd7,         "divu");
    run_op(4'd15, 32'd100,       32'd7,         "remu");
    run_op(4'd14, 32'd123,       32'd0,         "divu_by0");
    run_op(4'd15, 32'd123,       32'd0,         "remu_by0");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 40));
        2:       b = a;
        default: b = $urandom;
      endcase
      run_op(op, a, b, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp, a2, b2;
    int unstable;
    a = $urandom; b = $urandom; exp = a ^ b;
    a2 = $urandom; b2 = $urandom;
    unstable = 0;

    in_valid = 1'b1; Operation = 4'd6; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || ALUResult !== exp) begin
      bad++;
      $display("FAIL bp_first got valid=%b res=%h want valid=1 res=%h",
               out_valid, ALUResult, exp);
    end
    for (int i = 0; i < 10; i++) begin
      Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || ALUResult !== exp || in_ready !== 1'b0) unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL bp_hold got=%0d bad cycles want=0 (res=%h exp=%h)",
               unstable, ALUResult, exp);
    end
    $display("op=6 a=%h b=%h res=%h held 10 cycles (backpressure)", a, b, ALUResult);

    // Handshake edge: in_valid is high but nothing may be accepted here.
    Operation = 4'd2; SrcA = a2; SrcB = b2; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_no_overlap got valid=%b ready=%b want valid=0 ready=1",
               out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || ALUResult !== ref_model(4'd2, a2, b2)) begin
      bad++;
      $display("FAIL bp_next got valid=%b res=%h want valid=1 res=%h",
               out_valid, ALUResult, ref_model(4'd2, a2, b2));
    end
    $display("op=2 a=%h b=%h res=%h (after backpressure)", a2, b2, ALUResult);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    int rose;
    for (int k = 0; k < 2; k++) begin
      run_op(4'd2, 32'd1, 32'd2, "pre_abort");
      in_valid = 1'b1; Operation = 4'd14; SrcA = $urandom; SrcB = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || ALUResult !== 32'd0 || Zero !== 1'b0) begin
        bad++;
        $display("FAIL abort_state got ready=%b valid=%b res=%h zero=%b want 0 0 0 0",
                 in_ready, out_valid, ALUResult, Zero);
      end
      reset = 1'b0;
      #1;
      $display("divu aborted by reset in busy cycle 10 (pass %0d)", k);
      if (k == 0) begin
        rose = 0;
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          if (out_valid !== 1'b0) rose++;
        end
        total++;
        if (rose != 0) begin
          bad++;
          $display("FAIL abort_no_valid got=%0d cycles high want=0", rose);
        end
      end else begin
        // Accept straight away; a leftover divide would corrupt this result.
        run_op(4'd12, 32'd12345, 32'd678, "mul_after_abort");
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
